qwic51_ifetch: RTL and testbench

Instruction fetch unit sitting directly upstream of the qwic51 core. Given the core's program-counter address, it reads the synchronous program ROM and presents the opcode/operand byte on the core's instruction-register input. In prefetch builds it runs ahead sequentially into a small FIFO, so in-line code hits with 1-cycle latency. Any non-sequential PC, such as a jump, call, return or interrupt, flushes the FIFO.

---
 rtl/qwic51_ifetch.sv | 174 +++++++++++++++++
 tb/tb_qwic51_ifetch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/qwic51_ifetch.sv
// qwic51_ifetch: instruction fetch unit feeding the qwic51 core IR input.
// Build option QWIC51_IFETCH_PREFETCH_EN enables the sequential run-ahead
// FIFO; without it every request is fetched on demand with miss timing.
//
// Handshake: PC_REQ is a one-cycle pulse with PC_ADDR valid in the same
// cycle; the unit always accepts it. IR_VALID is a one-cycle pulse marking
// the cycle IR_REG was loaded with the byte for the most recent request. A
// new PC_REQ while BUSY replaces the pending request; the old one is dropped.
module qwic51_ifetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RESET,
  input  logic [ADDR_WIDTH-1:0] PC_ADDR,
  input  logic                  PC_REQ,
  output logic [DATA_WIDTH-1:0] IR_REG,
  output logic                  IR_VALID,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] ROM_ADDR,
  output logic                  ROM_RD,
  input  logic [DATA_WIDTH-1:0] ROM_RD_DATA
);

  // In-flight reads: ROM_RD/ROM_ADDR is stage 0, stage ROM_LAT is the read
  // whose data is on ROM_RD_DATA this cycle.
  logic [ROM_LAT:1]      inf_v;
  logic [ADDR_WIDTH-1:0] inf_a [1:ROM_LAT];

  logic                  pr_v;
  logic [ADDR_WIDTH-1:0] pr_a;
  logic                  pr_v_n;
  logic [ADDR_WIDTH-1:0] pr_a_n;

  logic                  hit;
  logic                  is_wait;
  logic                  miss;
  logic [DATA_WIDTH-1:0] head_d;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_a;
  logic                  arr_live;
  logic                  bypass;
  logic                  deliver;

`ifdef QWIC51_IFETCH_PREFETCH_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] fa;
  logic [ADDR_WIDTH-1:0] fa_eff;
  logic [ADDR_WIDTH-1:0] f_a [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] f_d [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;
  logic                  old_v;
  logic [ADDR_WIDTH-1:0] old_a;
  logic                  push;
  int                    occ;

  // Classify the request against the FIFO head and the oldest in-flight read.
  always_comb begin
    old_v  = ROM_RD;
    old_a  = ROM_ADDR;
    occ    = ROM_RD ? 1 : 0;
    for (int k = 1; k <= ROM_LAT; k++) begin
      if (inf_v[k]) begin
        old_v = 1'b1;
        old_a = inf_a[k];
        occ   = occ + 1;
      end
    end
    occ     = occ + int'(cnt);
    head_d  = f_d[rd_ptr];
    hit     = PC_REQ && (cnt != '0) && (f_a[rd_ptr] == PC_ADDR);
    is_wait = PC_REQ && !hit && (cnt == '0) && old_v && (old_a == PC_ADDR);
  end

  // Issue the next sequential read while FIFO plus in-flight has room;
  // a miss restarts the stream at the requested address with an empty FIFO.
  always_comb begin
    fa_eff  = miss ? PC_ADDR : fa;
    issue   = miss || (occ < FIFO_DEPTH);
    issue_a = fa_eff;
    push    = arr_live && !bypass;
  end

  // Fetch pointer and FIFO pointers; a miss flushes everything.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RESET) begin
      fa     <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      fa <= issue ? fa_eff + ADDR_WIDTH'(1) : fa_eff;
      if (miss) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (hit)  rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + CW'(push) - CW'(hit);
      end
    end
  end

  // FIFO storage; entries are only meaningful between the pointers.
  always_ff @(posedge CPU_CLK) begin
    if (push) begin
      f_a[wr_ptr] <= inf_a[ROM_LAT];
      f_d[wr_ptr] <= ROM_RD_DATA;
    end
  end
`else
  // On-demand fetch: every request is a miss and issues exactly one read.
  assign hit     = 1'b0;
  assign is_wait = 1'b0;
  assign head_d  = '0;
  assign issue   = miss;
  assign issue_a = PC_ADDR;
`endif

  // Pending-request update and direct delivery of matching returning data.
  always_comb begin
    miss   = PC_REQ && !hit && !is_wait;
    pr_v_n = pr_v;
    pr_a_n = pr_a;
    if (hit) begin
      pr_v_n = 1'b0;
    end else if (PC_REQ) begin
      pr_v_n = 1'b1;
      pr_a_n = PC_ADDR;
    end
    arr_live = inf_v[ROM_LAT] && !miss;
    bypass   = arr_live && pr_v_n && (inf_a[ROM_LAT] == pr_a_n);
    deliver  = hit || bypass;
    if (bypass) pr_v_n = 1'b0;
  end

  // ROM strobe, in-flight valid shift, pending request and IR outputs.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RESET) begin
      inf_v    <= '0;
      pr_v     <= 1'b0;
      pr_a     <= '0;
      IR_REG   <= '0;
      IR_VALID <= 1'b0;
      ROM_RD   <= 1'b0;
      ROM_ADDR <= '0;
    end else begin
      ROM_RD <= issue;
      if (issue) ROM_ADDR <= issue_a;
      inf_v[1] <= ROM_RD && !miss;
      for (int k = 2; k <= ROM_LAT; k++) inf_v[k] <= inf_v[k-1] && !miss;
      pr_v     <= pr_v_n;
      pr_a     <= pr_a_n;
      IR_VALID <= deliver;
      if (deliver) IR_REG <= hit ? head_d : ROM_RD_DATA;
    end
  end

  // In-flight address tags follow the valid bits; no reset needed.
  always_ff @(posedge CPU_CLK) begin
    inf_a[1] <= ROM_ADDR;
    for (int k = 2; k <= ROM_LAT; k++) inf_a[k] <= inf_a[k-1];
  end

  assign BUSY = pr_v;

endmodule

// File: tb/tb_qwic51_ifetch.sv
// Testbench for qwic51_ifetch with a 1-cycle synchronous ROM whose contents
// are ROM[i] = i[7:0] ^ 8'h5A. Follows QWIC51_IFETCH_PREFETCH_EN when set.
module tb_qwic51_ifetch;

`ifdef QWIC51_IFETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk;
  logic        cpu_reset;
  logic [15:0] pc_addr;
  logic        pc_req;
  logic [7:0]  ir_reg;
  logic        ir_valid;
  logic        busy;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_q;

  int n_checks = 0;
  int n_fail   = 0;

  qwic51_ifetch #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .ROM_LAT(1), .FIFO_DEPTH(4)) dut (
    .CPU_CLK(clk), .CPU_RESET(cpu_reset), .PC_ADDR(pc_addr), .PC_REQ(pc_req),
    .IR_REG(ir_reg), .IR_VALID(ir_valid), .BUSY(busy),
    .ROM_ADDR(rom_addr), .ROM_RD(rom_rd), .ROM_RD_DATA(rom_q)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data one cycle after the strobe, junk otherwise
  always @(posedge clk) rom_q <= rom_rd ? (rom_addr[7:0] ^ 8'h5A) : 8'hEE;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle request pulse; returns in the cycle after the request
  task automatic req(input logic [15:0] a);
    pc_req  = 1'b1;
    pc_addr = a;
    tick();
    pc_req  = 1'b0;
  endtask

  task automatic test_reset();
    cpu_reset = 1'b1;
    tick();
    tick();
    n_checks++; if (ir_reg !== 8'h00) begin n_fail++; $display("FAIL reset_ir_reg: got %h want 00", ir_reg); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b want 0", ir_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rd: got %b want 0", rom_rd); end
    n_checks++; if (rom_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); end
    cpu_reset = 1'b0;
  endtask

  // request 0x0000 in the first cycle out of reset; 3-cycle miss, then stream
  task automatic test_first_miss();
    logic exp_rd;
    req(16'h0000);
    for (int k = 0; k < 7; k++) begin
      exp_rd = PF ? (k < 5) : (k == 0);
      n_checks++; if (rom_rd !== exp_rd) begin n_fail++; $display("FAIL first_rom_rd k=%0d: got %b want %b", k, rom_rd, exp_rd); end
      if (exp_rd) begin
        n_checks++; if (rom_addr !== 16'(k)) begin n_fail++; $display("FAIL first_rom_addr k=%0d: got %h want %h", k, rom_addr, 16'(k)); end
      end
      n_checks++; if (ir_valid !== (k == 2)) begin n_fail++; $display("FAIL first_ir_valid k=%0d: got %b", k, ir_valid); end
      n_checks++; if (busy !== (k < 2)) begin n_fail++; $display("FAIL first_busy k=%0d: got %b", k, busy); end
      if (k == 2) begin
        n_checks++; if (ir_reg !== 8'h5A) begin n_fail++; $display("FAIL first_ir_reg: got %h want 5a", ir_reg); end
      end
      tick();
    end
  endtask

  // jump away from a stream holding 0x0010..0x0013
  task automatic test_jump();
    req(16'h000F);
    tick();
    tick();
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'h55) begin n_fail++; $display("FAIL jump_setup: got v=%b ir=%h want v=1 ir=55", ir_valid, ir_reg); end
    repeat (5) tick();
    req(16'h0200);
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0200) begin n_fail++; $display("FAIL jump_rom: got rd=%b addr=%h want rd=1 addr=0200", rom_rd, rom_addr); end
    n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL jump_t1: got v=%b busy=%b want v=0 busy=1", ir_valid, busy); end
    tick();
    n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL jump_t2: got v=%b busy=%b want v=0 busy=1", ir_valid, busy); end
    tick();
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== rom(16'h0200)) begin n_fail++; $display("FAIL jump_t3: got v=%b ir=%h want v=1 ir=%h", ir_valid, ir_reg, rom(16'h0200)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL jump_busy_t3: got %b want 0", busy); end
  endtask

  // a request replaced while busy is never delivered
  task automatic test_replace();
    req(16'h0040);
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0040) begin n_fail++; $display("FAIL repl_rom_a: got rd=%b addr=%h want 0040", rom_rd, rom_addr); end
    req(16'h0041);
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0041) begin n_fail++; $display("FAIL repl_rom_b: got rd=%b addr=%h want 0041", rom_rd, rom_addr); end
    n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL repl_t2: got v=%b busy=%b want v=0 busy=1", ir_valid, busy); end
    tick();
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL repl_stale: got v=%b ir=%h want v=0", ir_valid, ir_reg); end
    tick();
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'h1B || busy !== 1'b0) begin n_fail++; $display("FAIL repl_deliver: got v=%b ir=%h busy=%b want v=1 ir=1b busy=0", ir_valid, ir_reg, busy); end
    tick();
  endtask

  // reset one cycle after the miss read: request dropped, clean restart
  task automatic test_reset_mid();
    req(16'h0030);
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0030) begin n_fail++; $display("FAIL rmid_rom: got rd=%b addr=%h want 0030", rom_rd, rom_addr); end
    tick();
    cpu_reset = 1'b1;
    tick();
    cpu_reset = 1'b0;
    n_checks++; if ({ir_reg, ir_valid, busy, rom_rd} !== 11'd0 || rom_addr !== 16'h0000) begin n_fail++; $display("FAIL rmid_zero: got ir=%h v=%b busy=%b rd=%b addr=%h want all 0", ir_reg, ir_valid, busy, rom_rd, rom_addr); end
    req(16'h0000);
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0000 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_t1: got rd=%b addr=%h v=%b", rom_rd, rom_addr, ir_valid); end
    tick();
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_t2: got v=%b ir=%h want v=0", ir_valid, ir_reg); end
    tick();
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'h5A) begin n_fail++; $display("FAIL rmid_t3: got v=%b ir=%h want v=1 ir=5a", ir_valid, ir_reg); end
    tick();
  endtask

`ifdef QWIC51_IFETCH_PREFETCH_EN
  // one request per cycle out of a full FIFO: a delivery every cycle
  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      pc_req  = 1'b1;
      pc_addr = 16'(i);
      tick();
      n_checks++; if (ir_valid !== 1'b1 || ir_reg !== rom(16'(i))) begin n_fail++; $display("FAIL b2b_%0d: got v=%b ir=%h want v=1 ir=%h", i, ir_valid, ir_reg, rom(16'(i))); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_%0d: got %b want 0", i, busy); end
    end
    pc_req = 1'b0;
    tick();
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got v=%b want 0", ir_valid); end
  endtask

  // called in the cycle 0x0200 is delivered: 0x0201 data is returning now
  task automatic test_wait();
    req(16'h0201);
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'h5B) begin n_fail++; $display("FAIL wait_deliver: got v=%b ir=%h want v=1 ir=5b", ir_valid, ir_reg); end
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0203) begin n_fail++; $display("FAIL wait_no_flush: got rd=%b addr=%h want rd=1 addr=0203", rom_rd, rom_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_busy: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_wrap();
    req(16'hFFFF);
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_rom_ffff: got rd=%b addr=%h", rom_rd, rom_addr); end
    tick();
    n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_rom_0000: got rd=%b addr=%h", rom_rd, rom_addr); end
    tick();
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'hA5) begin n_fail++; $display("FAIL wrap_ffff: got v=%b ir=%h want v=1 ir=a5", ir_valid, ir_reg); end
    tick();
    req(16'h0000);
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'h5A) begin n_fail++; $display("FAIL wrap_hit0: got v=%b ir=%h want v=1 ir=5a", ir_valid, ir_reg); end
    req(16'h0001);
    n_checks++; if (ir_valid !== 1'b1 || ir_reg !== 8'h5B) begin n_fail++; $display("FAIL wrap_hit1: got v=%b ir=%h want v=1 ir=5b", ir_valid, ir_reg); end
    tick();
  endtask
`else
  // on-demand build: every request costs the full miss latency
  task automatic test_seq_miss();
    for (int i = 1; i <= 4; i++) begin
      req(16'(i));
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy_%0d: got %b want 1", i, busy); end
      tick();
      n_checks++; if (rom_rd !== 1'b0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL seq_t2_%0d: got rd=%b v=%b want 0 0", i, rom_rd, ir_valid); end
      tick();
      n_checks++; if (ir_valid !== 1'b1 || ir_reg !== rom(16'(i))) begin n_fail++; $display("FAIL seq_%0d: got v=%b ir=%h want v=1 ir=%h", i, ir_valid, ir_reg, rom(16'(i))); end
    end
    tick();
    n_checks++; if (rom_rd !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL seq_idle: got rd=%b busy=%b want 0 0", rom_rd, busy); end
  endtask
`endif

  initial begin
    cpu_reset = 1'b1;
    pc_req    = 1'b0;
    pc_addr   = 16'h0000;
    test_reset();
    test_first_miss();
`ifdef QWIC51_IFETCH_PREFETCH_EN
    test_back_to_back();
    test_jump();
    test_wait();
    test_wrap();
`else
    test_seq_miss();
    test_jump();
    tick();
`endif
    test_replace();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
